hazard_ctrl: RTL and testbench

Parametrised pipeline hazard, forwarding and stall controller for the MIPS pipelined CPU. It sits beside `controller` and takes over its pipeline-control half. It is generalised to any number of post-ID forwarding stages and a configurable branch penalty. It adds behaviour the current controller lacks:
- a registered branch-shadow counter;
- a multi-cycle memory-busy hold;
- a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_fwd_select.sv | 63 ++++++
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / forwarding controller:
// controller state encodings, forwarding-select meaning and writeback source codes.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SHADOW = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALT   = 2'd3
    } hz_state_e;

    localparam int unsigned REG_ADDR_W = 5;

    // Forward select value 0 always means "read the register file".
    localparam int unsigned FWD_SEL_RF = 0;

    localparam logic WB_DATA_ALU = 1'b0;
    localparam logic WB_DATA_MEM = 1'b1;

    function automatic int unsigned fwd_sel_width(input int unsigned num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding source picker for one ID operand: youngest matching writer wins,
// a too-young load result turns into a load-use stall request instead.
module hazard_ctrl_fwd_select
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FWD_STAGES   = 2,
    parameter int unsigned LOAD_READY_STAGE = 2,
    parameter int unsigned SEL_W            = 2
) (
    input  logic                                 used,
    input  logic [REG_ADDR_W-1:0]                addr,
    input  logic [REG_ADDR_W*NUM_FWD_STAGES-1:0] regw_addr_pipe,
    input  logic [NUM_FWD_STAGES-1:0]            wb_wen_pipe,
    input  logic [NUM_FWD_STAGES-1:0]            wb_from_mem_pipe,
    output logic [SEL_W-1:0]                     sel_c,
    output logic                                 load_use_c
);

    logic [NUM_FWD_STAGES-1:0] match;
    logic [NUM_FWD_STAGES-1:0] match_sh;
    logic [NUM_FWD_STAGES-1:0] mem_sh;
    logic                      hit;
    logic                      hit_mem;
    int unsigned               hit_k;

    for (genvar g = 0; g < NUM_FWD_STAGES; g++) begin : g_match
        assign match[g] = wb_wen_pipe[g] &&
                          (regw_addr_pipe[REG_ADDR_W*g +: REG_ADDR_W] == addr);
    end

    // Scan oldest to youngest so the lowest stage index is written last and wins.
    always_comb begin
        hit      = 1'b0;
        hit_mem  = WB_DATA_ALU;
        hit_k    = FWD_SEL_RF;
        match_sh = '0;
        mem_sh   = '0;
        if (used && (addr != '0)) begin
            for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
                match_sh = match >> i;
                mem_sh   = wb_from_mem_pipe >> i;
                if (match_sh[0]) begin
                    hit     = 1'b1;
                    hit_mem = mem_sh[0];
                    hit_k   = 32'(i) + 32'd1;
                end
            end
        end
    end

    always_comb begin
        sel_c      = SEL_W'(FWD_SEL_RF);
        load_use_c = 1'b0;
        if (hit) begin
            if ((hit_mem == WB_DATA_MEM) && (hit_k < LOAD_READY_STAGE)) begin
                load_use_c = 1'b1;
            end else begin
                sel_c = SEL_W'(hit_k);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch shadow
// bubbles, memory-busy hold, debug halt/single-step and a saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_FWD_STAGES   = 2,
    parameter  int unsigned LOAD_READY_STAGE = 2,
    parameter  int unsigned BRANCH_PENALTY   = 3,
    parameter  int unsigned CNT_W            = 32,
    localparam int unsigned SEL_W            = fwd_sel_width(NUM_FWD_STAGES)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 debug_en,
    input  logic                                 debug_step,
    input  logic [REG_ADDR_W-1:0]                rs_addr,
    input  logic [REG_ADDR_W-1:0]                rt_addr,
    input  logic                                 rs_used,
    input  logic                                 rt_used,
    input  logic                                 id_valid,
    input  logic                                 id_is_branch,
    input  logic [REG_ADDR_W*NUM_FWD_STAGES-1:0] regw_addr_pipe,
    input  logic [NUM_FWD_STAGES-1:0]            wb_wen_pipe,
    input  logic [NUM_FWD_STAGES-1:0]            wb_from_mem_pipe,
    input  logic                                 mem_busy,
    output logic [SEL_W-1:0]                     fwd_a_sel,
    output logic [SEL_W-1:0]                     fwd_b_sel,
    output logic                                 if_en,
    output logic                                 id_en,
    output logic                                 exe_en,
    output logic                                 mem_en,
    output logic                                 wb_en,
    output logic                                 id_flush,
    output logic                                 exe_flush,
    output logic [CNT_W-1:0]                     stall_cycles
);

    localparam int unsigned BR_W = $clog2(BRANCH_PENALTY + 1);
    localparam logic [BR_W-1:0] BR_LOAD = BR_W'(BRANCH_PENALTY - 1);

    hz_state_e        state, state_n;
    hz_state_e        saved, saved_n;
    hz_state_e        eff_state, base_state;
    logic [BR_W-1:0]  br_cnt, br_cnt_n, base_cnt;
    logic             step_prev;
    logic [CNT_W-1:0] stall_n;

    logic [SEL_W-1:0] sel_a, sel_b;
    logic             lu_a, lu_b;
    logic             load_use;
    logic             step_edge;
    logic             halted;
    logic             advance;
    logic             accept;
    logic             stall_inc;

    hazard_ctrl_fwd_select #(
        .NUM_FWD_STAGES  (NUM_FWD_STAGES),
        .LOAD_READY_STAGE(LOAD_READY_STAGE),
        .SEL_W           (SEL_W)
    ) u_fwd_a (
        .used            (rs_used),
        .addr            (rs_addr),
        .regw_addr_pipe  (regw_addr_pipe),
        .wb_wen_pipe     (wb_wen_pipe),
        .wb_from_mem_pipe(wb_from_mem_pipe),
        .sel_c           (sel_a),
        .load_use_c      (lu_a)
    );

    hazard_ctrl_fwd_select #(
        .NUM_FWD_STAGES  (NUM_FWD_STAGES),
        .LOAD_READY_STAGE(LOAD_READY_STAGE),
        .SEL_W           (SEL_W)
    ) u_fwd_b (
        .used            (rt_used),
        .addr            (rt_addr),
        .regw_addr_pipe  (regw_addr_pipe),
        .wb_wen_pipe     (wb_wen_pipe),
        .wb_from_mem_pipe(wb_from_mem_pipe),
        .sel_c           (sel_b),
        .load_use_c      (lu_b)
    );

    assign load_use  = lu_a | lu_b;
    assign step_edge = debug_step & ~step_prev;
    assign halted    = debug_en & ~step_edge;
    assign advance   = ~halted & ~mem_busy & ~load_use;
    assign accept    = id_valid & id_is_branch & advance & (br_cnt == '0);
    assign stall_inc = (load_use | mem_busy) & ~halted;

    // HOLD/HALT park the interrupted RUN/SHADOW state in saved.
    assign eff_state = ((state == ST_HOLD) || (state == ST_HALT)) ? saved : state;

    always_comb begin
        state_n    = state;
        saved_n    = saved;
        br_cnt_n   = br_cnt;
        base_state = eff_state;
        base_cnt   = br_cnt;
        if (advance) begin
            if (accept) begin
                if (BRANCH_PENALTY > 1) begin
                    base_state = ST_SHADOW;
                    base_cnt   = BR_LOAD;
                end
            end else if (eff_state == ST_SHADOW) begin
                base_cnt = br_cnt - BR_W'(1);
                if (base_cnt == '0) begin
                    base_state = ST_RUN;
                end
            end
        end
        br_cnt_n = base_cnt;
        saved_n  = base_state;
        if (debug_en) begin
            state_n = ST_HALT;
        end else if (mem_busy) begin
            state_n = ST_HOLD;
        end else begin
            state_n = base_state;
        end
    end

    always_comb begin
        stall_n = stall_cycles;
        if (stall_inc && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_n = stall_cycles + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            saved        <= ST_RUN;
            br_cnt       <= '0;
            step_prev    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_n;
            saved        <= saved_n;
            br_cnt       <= br_cnt_n;
            step_prev    <= debug_step;
            stall_cycles <= stall_n;
        end
    end

    // Reset forces every control output quiet immediately, not at the next edge.
    always_comb begin
        if_en     = 1'b0;
        id_en     = 1'b0;
        exe_en    = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        id_flush  = 1'b0;
        exe_flush = 1'b0;
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        if (rst_n) begin
            fwd_a_sel = sel_a;
            fwd_b_sel = sel_b;
            if (halted || mem_busy) begin
                if_en = 1'b0;
            end else if (load_use) begin
                exe_en    = 1'b1;
                mem_en    = 1'b1;
                wb_en     = 1'b1;
                exe_flush = 1'b1;
            end else begin
                if_en    = 1'b1;
                id_en    = 1'b1;
                exe_en   = 1'b1;
                mem_en   = 1'b1;
                wb_en    = 1'b1;
                id_flush = accept | (br_cnt != '0);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding vector table plus hand-written
// sequences for load-use, branch shadow, memory hold, debug step and reset.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       debug_en;
    logic       debug_step;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic       rs_used;
    logic       rt_used;
    logic       id_valid;
    logic       id_is_branch;
    logic [9:0] regw_addr_pipe;
    logic [1:0] wb_wen_pipe;
    logic [1:0] wb_from_mem_pipe;
    logic       mem_busy;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       if_en, id_en, exe_en, mem_en, wb_en;
    logic       id_flush, exe_flush;
    logic [3:0] stall_cycles;

    int n_tests;
    int n_fail;

    hazard_ctrl #(
        .NUM_FWD_STAGES  (2),
        .LOAD_READY_STAGE(2),
        .BRANCH_PENALTY  (3),
        .CNT_W           (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .debug_en        (debug_en),
        .debug_step      (debug_step),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rs_used         (rs_used),
        .rt_used         (rt_used),
        .id_valid        (id_valid),
        .id_is_branch    (id_is_branch),
        .regw_addr_pipe  (regw_addr_pipe),
        .wb_wen_pipe     (wb_wen_pipe),
        .wb_from_mem_pipe(wb_from_mem_pipe),
        .mem_busy        (mem_busy),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .if_en           (if_en),
        .id_en           (id_en),
        .exe_en          (exe_en),
        .mem_en          (mem_en),
        .wb_en           (wb_en),
        .id_flush        (id_flush),
        .exe_flush       (exe_flush),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_u;
        logic       rt_u;
        logic [9:0] regw;
        logic [1:0] wen;
        logic [1:0] from_mem;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic       exp_lu;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        debug_en         = 1'b0;
        debug_step       = 1'b0;
        rs_addr          = 5'd0;
        rt_addr          = 5'd0;
        rs_used          = 1'b0;
        rt_used          = 1'b0;
        id_valid         = 1'b0;
        id_is_branch     = 1'b0;
        regw_addr_pipe   = 10'd0;
        wb_wen_pipe      = 2'b00;
        wb_from_mem_pipe = 2'b00;
        mem_busy         = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_load_use_r7();
        rt_addr          = 5'd7;
        rt_used          = 1'b1;
        regw_addr_pipe   = {5'd0, 5'd7};
        wb_wen_pipe      = 2'b01;
        wb_from_mem_pipe = 2'b01;
    endtask

    int flush_cnt;
    int en_cnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst_n = 1'b0;

        //               rs     rt     rsu   rtu   regw {s2,s1}    wen    mem    a      b      lu
        vecs[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, {5'd0, 5'd5}, 2'b01, 2'b00, 2'd1, 2'd0, 1'b0};
        vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, {5'd5, 5'd0}, 2'b10, 2'b00, 2'd2, 2'd0, 1'b0};
        vecs[2]  = '{5'd5, 5'd0, 1'b1, 1'b0, {5'd5, 5'd5}, 2'b11, 2'b00, 2'd1, 2'd0, 1'b0};
        vecs[3]  = '{5'd0, 5'd7, 1'b0, 1'b1, {5'd0, 5'd7}, 2'b01, 2'b01, 2'd0, 2'd0, 1'b1};
        vecs[4]  = '{5'd0, 5'd7, 1'b0, 1'b1, {5'd7, 5'd0}, 2'b10, 2'b10, 2'd0, 2'd2, 1'b0};
        vecs[5]  = '{5'd0, 5'd0, 1'b1, 1'b0, {5'd0, 5'd0}, 2'b01, 2'b00, 2'd0, 2'd0, 1'b0};
        vecs[6]  = '{5'd5, 5'd0, 1'b0, 1'b0, {5'd0, 5'd5}, 2'b01, 2'b00, 2'd0, 2'd0, 1'b0};
        vecs[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, {5'd0, 5'd5}, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0};
        vecs[8]  = '{5'd3, 5'd3, 1'b1, 1'b1, {5'd0, 5'd3}, 2'b01, 2'b00, 2'd1, 2'd1, 1'b0};
        vecs[9]  = '{5'd4, 5'd9, 1'b1, 1'b1, {5'd4, 5'd9}, 2'b11, 2'b10, 2'd2, 2'd1, 1'b0};
        vecs[10] = '{5'd0, 5'd7, 1'b0, 1'b1, {5'd7, 5'd7}, 2'b11, 2'b01, 2'd0, 2'd0, 1'b1};
        vecs[11] = '{5'd6, 5'd6, 1'b1, 1'b1, {5'd6, 5'd6}, 2'b11, 2'b11, 2'd0, 2'd0, 1'b1};

        // Outputs held quiet while reset is asserted.
        #3;
        chk("rst_if_en", 32'(if_en), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_id_flush", 32'(id_flush), 32'd0);
        chk("rst_exe_flush", 32'(exe_flush), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Forwarding table.
        for (int i = 0; i < 12; i++) begin
            rs_addr          = vecs[i].rs;
            rt_addr          = vecs[i].rt;
            rs_used          = vecs[i].rs_u;
            rt_used          = vecs[i].rt_u;
            regw_addr_pipe   = vecs[i].regw;
            wb_wen_pipe      = vecs[i].wen;
            wb_from_mem_pipe = vecs[i].from_mem;
            @(negedge clk);
            chk($sformatf("vec%0d_fwd_a", i), 32'(fwd_a_sel), 32'(vecs[i].exp_a));
            chk($sformatf("vec%0d_fwd_b", i), 32'(fwd_b_sel), 32'(vecs[i].exp_b));
            chk($sformatf("vec%0d_if_en", i), 32'(if_en), 32'(!vecs[i].exp_lu));
            chk($sformatf("vec%0d_id_en", i), 32'(id_en), 32'(!vecs[i].exp_lu));
            chk($sformatf("vec%0d_exe_flush", i), 32'(exe_flush), 32'(vecs[i].exp_lu));
            chk($sformatf("vec%0d_exe_en", i), 32'(exe_en), 32'd1);
            next_cycle();
        end

        // Load-use stall then forward from stage 2.
        do_reset();
        set_load_use_r7();
        @(negedge clk);
        chk("lu_if_en", 32'(if_en), 32'd0);
        chk("lu_exe_flush", 32'(exe_flush), 32'd1);
        chk("lu_stall0", 32'(stall_cycles), 32'd0);
        next_cycle();
        regw_addr_pipe   = {5'd7, 5'd0};
        wb_wen_pipe      = 2'b10;
        wb_from_mem_pipe = 2'b10;
        @(negedge clk);
        chk("lu_fwd_b2", 32'(fwd_b_sel), 32'd2);
        chk("lu_if_en_after", 32'(if_en), 32'd1);
        chk("lu_stall1", 32'(stall_cycles), 32'd1);
        next_cycle();

        // Branch shadow: exactly three flush cycles.
        do_reset();
        id_valid     = 1'b1;
        id_is_branch = 1'b1;
        flush_cnt    = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("br_flush_c%0d", c), 32'(id_flush), 32'(c < 3));
            chk($sformatf("br_if_en_c%0d", c), 32'(if_en), 32'd1);
            if (id_flush) flush_cnt++;
            next_cycle();
            id_valid     = 1'b0;
            id_is_branch = 1'b0;
        end
        chk("br_flush_total", 32'(flush_cnt), 32'd3);

        // Memory busy arriving in the second shadow cycle freezes the bubble count.
        do_reset();
        id_valid     = 1'b1;
        id_is_branch = 1'b1;
        @(negedge clk);
        chk("hold_accept_flush", 32'(id_flush), 32'd1);
        next_cycle();
        idle();
        mem_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("hold_if_en_c%0d", c), 32'(if_en), 32'd0);
            chk($sformatf("hold_wb_en_c%0d", c), 32'(wb_en), 32'd0);
            chk($sformatf("hold_flush_c%0d", c), 32'(id_flush), 32'd0);
            next_cycle();
        end
        mem_busy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold_after_flush_c%0d", c), 32'(id_flush), 32'(c < 2));
            next_cycle();
        end
        chk("hold_stall4", 32'(stall_cycles), 32'd4);

        // Debug halt: two step pulses give two cycles, a held step gives one.
        do_reset();
        debug_en = 1'b1;
        en_cnt   = 0;
        for (int c = 0; c < 10; c++) begin
            debug_step = (c == 2) || (c == 6);
            @(negedge clk);
            if (if_en && wb_en) en_cnt++;
            next_cycle();
        end
        chk("dbg_pulse_cycles", 32'(en_cnt), 32'd2);
        en_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            debug_step = (c != 0);
            @(negedge clk);
            if (if_en && wb_en) en_cnt++;
            next_cycle();
        end
        chk("dbg_held_cycles", 32'(en_cnt), 32'd1);
        debug_en   = 1'b0;
        debug_step = 1'b0;
        @(negedge clk);
        chk("dbg_resume_if_en", 32'(if_en), 32'd1);
        next_cycle();

        // Halted cycles never count; busy plus load-use counts once with no flush.
        do_reset();
        debug_en = 1'b1;
        mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) next_cycle();
        @(negedge clk);
        chk("halt_busy_stall0", 32'(stall_cycles), 32'd0);
        next_cycle();
        debug_en = 1'b0;
        set_load_use_r7();
        @(negedge clk);
        chk("busy_lu_if_en", 32'(if_en), 32'd0);
        chk("busy_lu_exe_flush", 32'(exe_flush), 32'd0);
        chk("busy_lu_exe_en", 32'(exe_en), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("busy_lu_stall1", 32'(stall_cycles), 32'd1);
        next_cycle();

        // Counter saturation at all-ones.
        do_reset();
        mem_busy = 1'b1;
        for (int c = 0; c < 20; c++) next_cycle();
        mem_busy = 1'b0;
        @(negedge clk);
        chk("stall_saturate", 32'(stall_cycles), 32'd15);
        next_cycle();

        // Asynchronous reset in the middle of a shadow.
        do_reset();
        set_load_use_r7();
        next_cycle();
        idle();
        id_valid     = 1'b1;
        id_is_branch = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        chk("mid_shadow_flush", 32'(id_flush), 32'd1);
        chk("mid_shadow_stall", 32'(stall_cycles), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flush", 32'(id_flush), 32'd0);
        chk("async_rst_if_en", 32'(if_en), 32'd0);
        chk("async_rst_stall", 32'(stall_cycles), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_flush", 32'(id_flush), 32'd0);
        chk("post_rst_if_en", 32'(if_en), 32'd1);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
